// File: rtl/fp_align_pipe.sv
// fp_align_pipe: two-stage pipelined operand aligner for the FP adder.
//   Stage 1 classifies both operands, orders them by magnitude and computes the exponent difference.
//   Stage 2 right-shifts the smaller significand to the larger exponent and folds lost bits into sticky.
// Ports:
//   clk, reset_n                  clock, asynchronous active-low reset
//   in_valid/in_ready, op_a/op_b  upstream handshake and packed {sign, exponent, fraction} operands
//   out_valid/out_ready           downstream handshake
//   sign_big/sign_small/swapped   ordering result (swapped=1 when op_b is larger)
//   exp_out, man_big, man_small   larger effective exponent and aligned significands (man_small LSB is sticky)
//   bypass, a/b_nan/inf/zero      special-operand class flags
module fp_align_pipe #(
   parameter int EXP_W = 8,
   parameter int MAN_W = 23,
   parameter int EXT_W = 3,
   localparam int SIG_W = 1 + MAN_W + EXT_W,
   localparam int OP_W = 1 + EXP_W + MAN_W
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [OP_W-1:0]  op_a,
   input  logic [OP_W-1:0]  op_b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             sign_big,
   output logic             sign_small,
   output logic             swapped,
   output logic [EXP_W-1:0] exp_out,
   output logic [SIG_W-1:0] man_big,
   output logic [SIG_W-1:0] man_small,
   output logic             bypass,
   output logic             a_nan,
   output logic             b_nan,
   output logic             a_inf,
   output logic             b_inf,
   output logic             a_zero,
   output logic             b_zero
);
   logic             v1_q, v2_q, adv1, adv2;
   logic             a_s, b_s, a_h, b_h, swap_d;
   logic [EXP_W-1:0] a_e, b_e, a_eff, b_eff;
   logic [MAN_W-1:0] a_f, b_f;
   logic [5:0]       flags_d, flags1_q, flags2_q;
   logic             byp1_q, sb1_q, ss1_q, sw1_q;
   logic [EXP_W-1:0] e1_q, diff_d, diff1_q;
   logic [MAN_W:0]   big1_q, small1_q;
   logic             byp2_q, sb2_q, ss2_q, sw2_q;
   logic [EXP_W-1:0] e2_q;
   logic [SIG_W-1:0] big2_q, small2_q;
   logic [SIG_W-1:0] ext, shifted, man_small_d;
   logic [2*SIG_W-1:0] wide;
   logic             far, sticky;

   assign adv2     = !v2_q || out_ready;
   assign adv1     = !v1_q || adv2;
   assign in_ready = adv1;

   assign a_s = op_a[OP_W-1];
   assign b_s = op_b[OP_W-1];
   assign a_e = op_a[MAN_W +: EXP_W];
   assign b_e = op_b[MAN_W +: EXP_W];
   assign a_f = op_a[MAN_W-1:0];
   assign b_f = op_b[MAN_W-1:0];
   // A zero exponent field (zero or subnormal) behaves as exponent 1 with no hidden bit.
   assign a_h   = |a_e;
   assign b_h   = |b_e;
   assign a_eff = a_h ? a_e : EXP_W'(1);
   assign b_eff = b_h ? b_e : EXP_W'(1);
   // Comparing hidden bits with the fraction keeps a subnormal below a normal sharing exponent 1.
   assign swap_d  = {b_eff, b_h, b_f} > {a_eff, a_h, a_f};
   assign diff_d  = swap_d ? b_eff - a_eff : a_eff - b_eff;
   assign flags_d = {&a_e & |a_f, &b_e & |b_f, &a_e & ~|a_f, &b_e & ~|b_f, ~|a_e & ~|a_f, ~|b_e & ~|b_f};

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         v1_q     <= 1'b0;
         flags1_q <= '0;
         byp1_q   <= 1'b0;
         sb1_q    <= 1'b0;
         ss1_q    <= 1'b0;
         sw1_q    <= 1'b0;
         e1_q     <= '0;
         diff1_q  <= '0;
         big1_q   <= '0;
         small1_q <= '0;
      end else if (adv1) begin
         v1_q <= in_valid;
         if (in_valid) begin
            flags1_q <= flags_d;
            byp1_q   <= |flags_d;
            sb1_q    <= swap_d ? b_s : a_s;
            ss1_q    <= swap_d ? a_s : b_s;
            sw1_q    <= swap_d;
            e1_q     <= swap_d ? b_eff : a_eff;
            diff1_q  <= diff_d;
            big1_q   <= swap_d ? {b_h, b_f} : {a_h, a_f};
            small1_q <= swap_d ? {a_h, a_f} : {b_h, b_f};
         end
      end
   end

   // The low half of the double-width shift collects exactly the bits shifted out.
   assign ext         = {small1_q, EXT_W'(0)};
   assign wide        = {ext, SIG_W'(0)} >> diff1_q;
   assign far         = int'(diff1_q) >= SIG_W;
   assign shifted     = far ? '0 : wide[2*SIG_W-1:SIG_W];
   assign sticky      = far ? |ext : (|wide[SIG_W-1:0]) | shifted[0];
   assign man_small_d = {shifted[SIG_W-1:1], sticky};

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         v2_q     <= 1'b0;
         flags2_q <= '0;
         byp2_q   <= 1'b0;
         sb2_q    <= 1'b0;
         ss2_q    <= 1'b0;
         sw2_q    <= 1'b0;
         e2_q     <= '0;
         big2_q   <= '0;
         small2_q <= '0;
      end else if (adv2) begin
         v2_q <= v1_q;
         if (v1_q) begin
            flags2_q <= flags1_q;
            byp2_q   <= byp1_q;
            sb2_q    <= sb1_q;
            ss2_q    <= ss1_q;
            sw2_q    <= sw1_q;
            e2_q     <= e1_q;
            big2_q   <= {big1_q, EXT_W'(0)};
            small2_q <= man_small_d;
         end
      end
   end

   assign out_valid  = v2_q;
   assign sign_big   = sb2_q;
   assign sign_small = ss2_q;
   assign swapped    = sw2_q;
   assign exp_out    = e2_q;
   assign man_big    = big2_q;
   assign man_small  = small2_q;
   assign bypass     = byp2_q;
   assign {a_nan, b_nan, a_inf, b_inf, a_zero, b_zero} = flags2_q;
endmodule

// File: tb/tb_fp_align_pipe.sv
// tb_fp_align_pipe: directed self-checking bench for fp_align_pipe in single-precision configuration.
module tb_fp_align_pipe;
   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [31:0] op_a = '0;
   logic [31:0] op_b = '0;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic        sign_big, sign_small, swapped, bypass;
   logic [7:0]  exp_out;
   logic [26:0] man_big, man_small;
   logic        a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
   int          n_chk = 0;
   int          n_err = 0;

   fp_align_pipe dut (
      .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
      .op_a(op_a), .op_b(op_b), .out_valid(out_valid), .out_ready(out_ready),
      .sign_big(sign_big), .sign_small(sign_small), .swapped(swapped), .exp_out(exp_out),
      .man_big(man_big), .man_small(man_small), .bypass(bypass),
      .a_nan(a_nan), .b_nan(b_nan), .a_inf(a_inf), .b_inf(b_inf), .a_zero(a_zero), .b_zero(b_zero)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Presents one pair for one cycle; returns when its result is on the outputs.
   task automatic send(input logic [31:0] a, input logic [31:0] b);
      @(negedge clk);
      op_a = a;
      op_b = b;
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      chk("lat_stage1", out_valid, 0);
      @(negedge clk);
      chk("lat_stage2", out_valid, 1);
   endtask

   initial begin
      int k, n, first_ret, last_ret;
      logic acc;
      #1;
      chk("rst_out_valid", out_valid, 0);
      chk("rst_exp", exp_out, 0);
      chk("rst_man_small", man_small, 0);
      @(negedge clk);
      reset_n = 1'b1;
      #1;
      chk("rst_in_ready", in_ready, 1);

      send(32'h3F800000, 32'h3F800000);
      chk("eq_exp", exp_out, 8'h7F);
      chk("eq_big", man_big, 27'h4000000);
      chk("eq_small", man_small, 27'h4000000);
      chk("eq_swapped", swapped, 0);
      chk("eq_bypass", bypass, 0);

      send(32'h30800000, 32'h3F800000);
      chk("far_swapped", swapped, 1);
      chk("far_exp", exp_out, 8'h7F);
      chk("far_small", man_small, 27'h0000001);
      chk("far_big", man_big, 27'h4000000);

      send(32'h3F800000, 32'h3F400000);
      chk("d1_small", man_small, 27'h3000000);
      chk("d1_swapped", swapped, 0);

      // ext = 7FFFFF8; >>1 = 3FFFFFC, the bit shifted out is 0 so sticky stays 0
      send(32'h3F800000, 32'h3F7FFFFF);
      chk("d1_all_ones_small", man_small, 27'h3FFFFFC);
      chk("d1_all_ones_exp", exp_out, 8'h7F);

      send(32'h00000001, 32'h00800000);
      chk("sub_exp", exp_out, 8'h01);
      chk("sub_swapped", swapped, 1);
      chk("sub_small", man_small, 27'h0000008);
      chk("sub_big", man_big, 27'h4000000);

      send(32'hBF800000, 32'h40000000);
      chk("sign_swapped", swapped, 1);
      chk("sign_big", sign_big, 0);
      chk("sign_small", sign_small, 1);
      chk("sign_exp", exp_out, 8'h80);
      chk("sign_man_small", man_small, 27'h2000000);

      send(32'h7F800000, 32'h3F800000);
      chk("inf_flag", a_inf, 1);
      chk("inf_bypass", bypass, 1);
      chk("inf_small", man_small, 27'h0000001);

      // Backpressure: 4 pairs offered, out_ready low for the first 5 cycles
      k = 0;
      n = 0;
      first_ret = -1;
      last_ret = -1;
      for (int c = 0; c < 20 && n < 4; c++) begin
         @(negedge clk);
         out_ready = (c >= 5);
         in_valid = (k < 4);
         op_a = {1'b0, 8'(8'h80 + k), 23'h0};
         op_b = 32'h3F800000;
         #1;
         if (c == 2) chk("bp_in_ready_full", in_ready, 0);
         if (c == 4) begin
            chk("bp_accepts", k, 2);
            chk("bp_in_ready_stall", in_ready, 0);
            chk("bp_hold_valid", out_valid, 1);
            chk("bp_hold_exp", exp_out, 8'h80);
         end
         if (c == 5) chk("bp_release_ready", in_ready, 1);
         acc = in_valid & in_ready;
         if (out_valid && out_ready) begin
            chk("bp_order", exp_out, 8'(8'h80 + n));
            if (first_ret < 0) first_ret = c;
            last_ret = c;
            n++;
         end
         @(posedge clk);
         if (acc) k++;
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      chk("bp_count", n, 4);
      chk("bp_back_to_back", last_ret - first_ret, 3);
      chk("bp_first_ret", first_ret, 5);

      send(32'h7FC00000, 32'h00000000);
      chk("nan_a", a_nan, 1);
      chk("nan_b_zero", b_zero, 1);
      chk("nan_bypass", bypass, 1);
      chk("nan_a_zero", a_zero, 0);
      chk("nan_exp", exp_out, 8'hFF);
      chk("nan_big", man_big, 27'h6000000);
      chk("nan_small", man_small, 27'h0000000);

      // Fill both stages, then reset mid-stream
      out_ready = 1'b0;
      for (int c = 0; c < 2; c++) begin
         @(negedge clk);
         op_a = 32'h7FC00000;
         op_b = 32'h00000000;
         in_valid = 1'b1;
      end
      @(negedge clk);
      in_valid = 1'b0;
      #1;
      chk("mid_full_valid", out_valid, 1);
      chk("mid_full_ready", in_ready, 0);
      reset_n = 1'b0;
      #1;
      chk("mid_rst_valid", out_valid, 0);
      chk("mid_rst_nan", a_nan, 0);
      chk("mid_rst_big", man_big, 0);
      chk("mid_rst_bypass", bypass, 0);
      @(negedge clk);
      reset_n = 1'b1;
      out_ready = 1'b1;
      #1;
      chk("mid_rel_ready", in_ready, 1);
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         chk("mid_no_stale", out_valid, 0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
      $finish;
   end
endmodule
